ram_arbiter: RTL
================

# ram_arbiter

Round-robin arbiter and sequencer that shares the single-port RAM between NREQ requesters. Each requester issues one whole transaction: a write of (addr, data), or a read of addr. The block turns it into the RAM's two-phase 10-bit command protocol, {op, payload} on din qualified by rx_valid: WRITE_ADDR then WRITE_DATA, or READ_ADDR then READ_DATA. For reads it waits for tx_valid/dout and returns the result to the granted requester. It sits between the SPI slave and any other on-chip masters on one side and the RAM on the other.

## Interface
- NREQ, 2, number of requesters (2..8)
- RD_TIMEOUT, 16, cycles to wait in WAIT_RD for ram_tx_valid before flagging an error (>=2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  transaction request per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*8  packed, requester i at [8i+7:8i]
- req_wdata  in  NREQ*8  packed write data, same layout
- req_ready  out  NREQ  one-hot accept, combinational from state and grant
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  8  read data, shared; valid with rsp_valid
- rsp_err  out  1  read timeout; valid with rsp_valid
- busy  out  1  high whenever state != IDLE
- ram_din  out  10  {op[1:0], payload[7:0]} to RAM
- ram_rx_valid  out  1  command strobe to RAM
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read-data valid

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT_RD, RESP.
- IDLE:
  - If any req_valid is set, the rr_arbiter picks grant g, and req_ready[g]=1 that cycle.
  - On valid&&ready: latch g, we, addr, wdata; go to ADDR.
  - Otherwise req_ready is all zero.
- ADDR: drive ram_din = {we ? 2'b00 : 2'b10, addr}, ram_rx_valid=1; go to DATA.
- DATA:
  - Write: ram_din = {2'b01, wdata}, ram_rx_valid=1; go to RESP.
  - Read: ram_din = {2'b11, 8'h00}, ram_rx_valid=1; go to WAIT_RD with the timeout counter cleared.
- WAIT_RD:
  - If ram_tx_valid: capture ram_dout into rsp_rdata, rsp_err=0; go to RESP.
  - Else if the counter reaches RD_TIMEOUT-1: rsp_rdata=0, rsp_err=1; go to RESP.
  - Otherwise increment the counter.
- RESP: rsp_valid[g]=1 for exactly one cycle (writes: rsp_err=0, rsp_rdata=0); go to IDLE.
- Round-robin:
  - Pointer last holds the most recent grant; search starts at last+1 mod NREQ.
  - last updates only on acceptance.
  - Reset value NREQ-1, so requester 0 wins the first tie.
- Requesters must hold req_valid and all fields stable until req_ready; retraction is illegal.
- ram_tx_valid outside WAIT_RD is ignored.
- ram_rx_valid is never high in two consecutive cycles except ADDR→DATA of the same transaction.

## Timing
- All ram_* outputs, rsp_* and busy are registered; they change only on clk edges.
- Acceptance edge = cycle 0; the registered outputs follow by cycle:
  - Cycle 1: ram_rx_valid=1 with the addr command (ADDR).
  - Cycle 2: ram_rx_valid=1 with the data/read command (DATA).
  - Write: rsp_valid high in cycle 3; the next acceptance can happen in cycle 4. Throughput is 1 write per 4 cycles.
  - Read, nominal RAM (tx_valid one cycle after the READ_DATA strobe, i.e. cycle 3): rsp_valid in cycle 4.
  - Read timeout: rsp_valid in cycle 3+RD_TIMEOUT.
- Simultaneous requests are served strictly in round-robin order. No requester waits more than NREQ-1 transactions.
- Reset values:
  - ram_din=0, ram_rx_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0.
  - State IDLE, last=NREQ-1, counter 0.
- Reset mid-transaction aborts it with no response. A RAM command already strobed is not undone; the requester must reissue.

## Structure
- shared_pkg: reuse the existing op_e (WRITE_ADDR=00, WRITE_DATA=01, READ_ADDR=10, READ_DATA=11) for the ram_din[9:8] encoding.
- Add arb_state_e {IDLE, ADDR, DATA, WAIT_RD, RESP} to shared_pkg.
- Sub-module rr_arbiter: parameter N; inputs req[N] and last; output one-hot grant (purely combinational).
- Top level holds the FSM, the latched transaction, the timeout counter and the output registers.

## Test plan
- Single write, req 0, addr 8'h3C, wdata 8'hA5 → ram_din 10'h03C then 10'h1A5 on consecutive strobes; rsp_valid[0] in cycle 3, rsp_err=0.
- Read, req 1, addr 8'h3C, RAM model returns 8'hA5 with tx_valid in cycle 3 → strobes 10'h23C, 10'h300; rsp_valid[1] in cycle 4 with rsp_rdata=8'hA5.
- Reqs 0 and 1 both held continuously after reset → grants alternate 0,1,0,1; each req_ready lasts one cycle; strobes are never interleaved between transactions.
- Read with RAM never asserting tx_valid, RD_TIMEOUT=16 → rsp_valid in cycle 19, rsp_err=1, rsp_rdata=8'h00; the next request is accepted normally.
- rst asserted in cycle 2 of a read → next cycle all outputs are at reset values with no rsp_valid; after release, a request from req 0 wins a tie with req 1.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types for the RAM command path: the RAM's two-phase opcode encoding
// and the arbiter sequencer states.
package shared_pkg;

  typedef enum logic [1:0] {
    WRITE_ADDR = 2'b00,
    WRITE_DATA = 2'b01,
    READ_ADDR  = 2'b10,
    READ_DATA  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RD,
    RESP
  } arb_state_e;

  localparam int CMD_W = 10;

  function automatic logic [CMD_W-1:0] mk_cmd(op_e op, logic [7:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last grant
// and wraps, so the most recently served requester has lowest priority.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant
);

  localparam int LW = $clog2(N);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between NREQ requesters: round-robin accept, then
// sequence each transaction into the RAM's two-strobe command protocol.
module ram_arbiter
  import shared_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [9:0]        ram_din,
  output logic              ram_rx_valid,
  input  logic [7:0]        ram_dout,
  input  logic              ram_tx_valid
);

  localparam int LW = $clog2(NREQ);
  localparam int CW = $clog2(RD_TIMEOUT);

  arb_state_e    state;
  logic [LW-1:0] last;
  logic [LW-1:0] gsel;
  logic [LW-1:0] gidx;
  logic [NREQ-1:0] grant;
  logic          we_q;
  logic [7:0]    wdata_q;
  logic [CW-1:0] cnt;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (req_valid),
    .last  (last),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = LW'(i);
    end
  end

  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  // The ram_* outputs are registered one edge ahead of the state they belong
  // to, so the ADDR command is issued on the acceptance edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= LW'(NREQ - 1);
      cnt          <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ram_rx_valid <= 1'b0;
      rsp_valid    <= '0;
      case (state)
        IDLE: begin
          if (|req_ready) begin
            gsel         <= gidx;
            last         <= gidx;
            we_q         <= req_we[gidx];
            wdata_q      <= req_wdata[int'(gidx)*8 +: 8];
            ram_din      <= mk_cmd(req_we[gidx] ? WRITE_ADDR : READ_ADDR,
                                   req_addr[int'(gidx)*8 +: 8]);
            ram_rx_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          ram_din      <= we_q ? mk_cmd(WRITE_DATA, wdata_q) : mk_cmd(READ_DATA, 8'h00);
          ram_rx_valid <= 1'b1;
          state        <= DATA;
        end
        DATA: begin
          if (we_q) begin
            rsp_valid[gsel] <= 1'b1;
            rsp_rdata       <= 8'h00;
            rsp_err         <= 1'b0;
            state           <= RESP;
          end else begin
            cnt   <= '0;
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (ram_tx_valid) begin
            rsp_valid[gsel] <= 1'b1;
            rsp_rdata       <= ram_dout;
            rsp_err         <= 1'b0;
            state           <= RESP;
          end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
            rsp_valid[gsel] <= 1'b1;
            rsp_rdata       <= 8'h00;
            rsp_err         <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
